// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg
// Shared constants, FSM encoding and the cell-index helper for the
// character-cell text buffer (char_buffer_writer and its RAM).
package char_buffer_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 60;
  localparam int DEF_CODE_W = 6;
  localparam int CELLS      = DEF_COLS * DEF_ROWS;
  localparam int IDX_W      = 13;   // covers 0..4799
  localparam int CELL_PX    = 8;    // 8x8 pixel cells

  // PicoBlaze output-port map
  localparam logic [7:0] PORT_COL  = 8'h10;
  localparam logic [7:0] PORT_ROW  = 8'h11;
  localparam logic [7:0] PORT_CHAR = 8'h12;
  localparam logic [7:0] PORT_CMD  = 8'h13;

  localparam logic [5:0] BLANK_CODE = 6'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // row*cols + col, truncated to the RAM address width
  function automatic logic [IDX_W-1:0] cell_index(input logic [6:0] row,
                                                  input logic [6:0] col,
                                                  input int cols);
    int idx;
    idx = int'(row) * cols + int'(col);
    return idx[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/char_ram_dp.sv
// char_ram_dp
// Simple dual-port character RAM: one synchronous write port, one
// registered read port. A read and write to the same address in the same
// cycle returns the old contents.
// Ports:
//   clk    - clock
//   rst    - async active-high reset of the read register only
//   we, waddr, wdata - write port
//   raddr  - read address, rdata valid one clock later
// Contents are not reset; on the FPGA the block RAM configures to zero.
module char_ram_dp #(
  parameter int DEPTH = 4800,
  parameter int WIDTH = 6,
  parameter int AW    = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Separate process so the array itself carries no reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];

endmodule

// File: rtl/char_buffer_writer.sv
// char_buffer_writer
// 80x60 character-cell buffer for the 640x480 VGA text display. Accepts
// cursor/character writes from the PicoBlaze output-port bus and produces
// the font ROM glyph-row address for the current pixel.
// Ports:
//   reloj, resetM          - clock, async active-high reset
//   port_id, out_port,
//   write_strobe           - PicoBlaze output-port bus
//   Qh, Qv                 - pixel counters
//   DIR8x8                 - {2'b00, code, 1'b0, Qv[2:0]}, 2 clocks after Qh/Qv
//   busy                   - clear sequence running
//   cursor_col, cursor_row - current write position
// Build option: CHAR_BUFFER_CLEAR_EN adds the CLEAR state, port 0x13 and
// an automatic clear after reset.
module char_buffer_writer
  import char_buffer_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic        reloj,
  input  logic        resetM,
  input  logic [7:0]  port_id,
  input  logic [7:0]  out_port,
  input  logic        write_strobe,
  input  logic [9:0]  Qh,
  input  logic [9:0]  Qv,
  output logic [11:0] DIR8x8,
  output logic        busy,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row
);

  localparam int                NCELLS   = COLS * ROWS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCELLS - 1);
  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
  localparam logic [5:0]        ROW_LAST = 6'(ROWS - 1);
  localparam logic [9:0]        H_ACTIVE = 10'(COLS * CELL_PX);
  localparam logic [9:0]        V_ACTIVE = 10'(ROWS * CELL_PX);

  state_t            state, state_nxt;
  logic [6:0]        cur_col, col_nxt, clamp_col;
  logic [5:0]        cur_row, row_nxt, clamp_row;
  logic [CODE_W-1:0] wr_code;
  logic              acc, set_col, set_row, do_write, go_clear;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [CODE_W-1:0] ram_wdata, rd_code;

  // ---------------- bus decode ----------------
  // Everything on the bus is dropped while clearing.
  assign acc      = write_strobe && (state != CLEAR);
  assign set_col  = acc && (port_id == PORT_COL);
  assign set_row  = acc && (port_id == PORT_ROW);
  assign do_write = acc && (port_id == PORT_CHAR);

  assign clamp_col = (out_port[6:0] > COL_LAST) ? COL_LAST : out_port[6:0];
  assign clamp_row = (out_port[5:0] > ROW_LAST) ? ROW_LAST : out_port[5:0];

`ifdef CHAR_BUFFER_CLEAR_EN
  logic [IDX_W-1:0] clr_idx;
  logic             boot_clr;   // requests one clear right after reset

  assign go_clear = boot_clr ||
                    (acc && (port_id == PORT_CMD) && out_port[0]);
  assign busy     = (state == CLEAR);

  always_ff @(posedge reloj or posedge resetM)
    if (resetM) begin
      clr_idx  <= '0;
      boot_clr <= 1'b1;
    end else begin
      clr_idx  <= (state == CLEAR && clr_idx != LAST_IDX) ?
                  clr_idx + IDX_W'(1) : '0;
      if (state == IDLE) boot_clr <= 1'b0;
    end
`else
  assign go_clear = 1'b0;
  assign busy     = 1'b0;
`endif

  // ---------------- FSM / cursor / write port ----------------
  always_comb begin
    state_nxt = state;
    col_nxt   = cur_col;
    row_nxt   = cur_row;
    ram_we    = 1'b0;
    ram_waddr = cell_index({1'b0, cur_row}, cur_col, COLS);
    ram_wdata = wr_code;
    case (state)
      IDLE, WRITE: begin
        if (state == WRITE) begin
          ram_we = 1'b1;
          if (cur_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + 6'd1;
          end else begin
            col_nxt = cur_col + 7'd1;
          end
        end
        // An explicit cursor write in the WRITE cycle overrides the advance
        // for that coordinate.
        if (set_col) col_nxt = clamp_col;
        if (set_row) row_nxt = clamp_row;
        if (go_clear)      state_nxt = CLEAR;
        else if (do_write) state_nxt = WRITE;
        else               state_nxt = IDLE;
      end
`ifdef CHAR_BUFFER_CLEAR_EN
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx;
        ram_wdata = CODE_W'(BLANK_CODE);
        if (clr_idx == LAST_IDX) begin
          state_nxt = IDLE;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge reloj or posedge resetM)
    if (resetM) begin
      state   <= IDLE;
      cur_col <= '0;
      cur_row <= '0;
      wr_code <= '0;
    end else begin
      state   <= state_nxt;
      cur_col <= col_nxt;
      cur_row <= row_nxt;
      if (do_write) wr_code <= out_port[CODE_W-1:0];
    end

  assign cursor_col = cur_col;
  assign cursor_row = cur_row;

  // ---------------- video read path ----------------
  // Stage 1 registers the cell index, stage 2 is the RAM read register.
  // Off-screen pixels read cell 0 and are masked to blank at the output.
  logic             vid_blank;
  logic [IDX_W-1:0] vid_idx_nxt, vid_idx;
  logic             blank_d1, blank_d2;
  logic [2:0]       qv_d1, qv_d2;

  assign vid_blank   = (Qh >= H_ACTIVE) || (Qv >= V_ACTIVE);
  assign vid_idx_nxt = vid_blank ? '0 : cell_index(Qv[9:3], Qh[9:3], COLS);

  always_ff @(posedge reloj or posedge resetM)
    if (resetM) begin
      vid_idx  <= '0;
      blank_d1 <= 1'b0;
      blank_d2 <= 1'b0;
      qv_d1    <= '0;
      qv_d2    <= '0;
    end else begin
      vid_idx  <= vid_idx_nxt;
      blank_d1 <= vid_blank;
      blank_d2 <= blank_d1;
      qv_d1    <= Qv[2:0];
      qv_d2    <= qv_d1;
    end

  char_ram_dp #(
    .DEPTH (NCELLS),
    .WIDTH (CODE_W),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (reloj),
    .rst   (resetM),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (vid_idx),
    .rdata (rd_code)
  );

  assign DIR8x8 = {2'b00, (blank_d2 ? 6'd0 : 6'(rd_code)), 1'b0, qv_d2};

  logic unused_in;
  assign unused_in = &{1'b0, out_port[7], Qh[2:0]};

endmodule

// File: tb/tb_char_buffer_writer.sv
`timescale 1ns/1ps
module tb_char_buffer_writer;

  logic        reloj = 1'b0;
  logic        resetM = 1'b1;
  logic [7:0]  port_id = 8'hFF;
  logic [7:0]  out_port = 8'h00;
  logic        write_strobe = 1'b0;
  logic [9:0]  Qh = '0;
  logic [9:0]  Qv = '0;
  logic [11:0] DIR8x8;
  logic        busy;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  int n_chk  = 0;
  int n_pass = 0;

  char_buffer_writer dut (
    .reloj        (reloj),
    .resetM       (resetM),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .Qh           (Qh),
    .Qv           (Qv),
    .DIR8x8       (DIR8x8),
    .busy         (busy),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row)
  );

  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // One-cycle port write; returns one clock after the strobe edge.
  task automatic pw(input logic [7:0] id, input logic [7:0] d);
    port_id      = id;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id      = 8'hFF;
  endtask

  task automatic rd_px(input int h, input int v, output logic [11:0] dir);
    Qh = 10'(h);
    Qv = 10'(v);
    tick();
    tick();
    dir = DIR8x8;
  endtask

  task automatic wait_idle(input string tag, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 6000) begin
      cnt++;
      tick();
    end
    if (cnt >= 6000) chk(tag, busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] v;
    int cnt, nz;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_dir", DIR8x8, 12'h000);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    resetM = 1'b0;
`ifdef CHAR_BUFFER_CLEAR_EN
    tick();
    chk("boot_busy", busy, 1);
    wait_idle("boot_timeout", cnt);
    chk("boot_len", cnt, 4800);
`else
    tick();
`endif

    // ---- cursor write and readback ----
    pw(8'h10, 8'd5);   chk("set_col", cursor_col, 5);
    pw(8'h11, 8'd3);   chk("set_row", cursor_row, 3);
    pw(8'h12, 8'h27);  chk("wr_n1_col", cursor_col, 5);
    tick();
    chk("wr_adv_col", cursor_col, 6);
    chk("wr_adv_row", cursor_row, 3);
    rd_px(40, 24, v);  chk("rd245_k0", v, 12'h270);
    rd_px(40, 29, v);  chk("rd245_k5", v, 12'h275);
    rd_px(40, 31, v);  chk("rd245_k7", v, 12'h277);

    // ---- same-cell read/write returns old data ----
    pw(8'h12, 8'h11);  tick();          // cell (6,3) = 0x11
    pw(8'h10, 8'd6);                    // back to (6,3)
    Qh = 10'd48; Qv = 10'd25;
    pw(8'h12, 8'h22);                   // index and WRITE line up
    tick();            chk("rw_old", DIR8x8, 12'h111);
    tick();            chk("rw_new", DIR8x8, 12'h221);

    // ---- back-to-back writes (WRITE -> WRITE) ----
    pw(8'h10, 8'd0);
    pw(8'h11, 8'd10);
    pw(8'h12, 8'h0A);
    pw(8'h12, 8'h0B);
    tick();
    chk("b2b_col", cursor_col, 2);
    chk("b2b_row", cursor_row, 10);
    rd_px(0, 80, v);   chk("b2b_c0", v, 12'h0A0);
    rd_px(8, 80, v);   chk("b2b_c1", v, 12'h0B0);

    // ---- row and screen wrap ----
    pw(8'h10, 8'd79);
    pw(8'h11, 8'd59);
    pw(8'h12, 8'h01);
    tick();
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 0);
    rd_px(632, 475, v); chk("rd4799", v, 12'h013);

    // ---- clamping ----
    pw(8'h10, 8'h7F);  chk("clamp_col7f", cursor_col, 79);
    pw(8'h10, 8'd80);  chk("clamp_col80", cursor_col, 79);
    pw(8'h10, 8'd78);  chk("noclamp_col78", cursor_col, 78);
    pw(8'h11, 8'h3F);  chk("clamp_row3f", cursor_row, 59);
    pw(8'h11, 8'd60);  chk("clamp_row60", cursor_row, 59);

    // ---- ignored ports ----
    pw(8'h10, 8'd4);
    pw(8'h11, 8'd2);
    pw(8'h00, 8'h05);
    pw(8'h14, 8'h00);
    chk("ign_col", cursor_col, 4);
    chk("ign_row", cursor_row, 2);
`ifndef CHAR_BUFFER_CLEAR_EN
    pw(8'h13, 8'h01);
    chk("cmd_ign_busy", busy, 0);
    pw(8'h10, 8'd9);
    chk("cmd_ign_next", cursor_col, 9);
`endif

    // ---- blanking ----
    pw(8'h10, 8'd0);  pw(8'h11, 8'd0);
    pw(8'h12, 8'h2B); tick();           // cell 0
    pw(8'h11, 8'd1);
    pw(8'h12, 8'h2A); tick();           // cell 81
    pw(8'h10, 8'd0);
    pw(8'h12, 8'h29); tick();           // cell 80
    rd_px(0, 0, v);     chk("rd_c0", v, 12'h2B0);
    rd_px(8, 10, v);    chk("rd_c81", v, 12'h2A2);
    rd_px(650, 2, v);   chk("blank_h650", v, 12'h002);
    rd_px(8, 490, v);   chk("blank_v490", v, 12'h002);
    rd_px(640, 1, v);   chk("blank_h640", v, 12'h001);
    rd_px(0, 480, v);   chk("blank_v480", v, 12'h000);
    rd_px(639, 479, v); chk("edge_639_479", v, 12'h017);

`ifdef CHAR_BUFFER_CLEAR_EN
    // ---- clear ----
    pw(8'h13, 8'h02);  chk("cmd_bit0_0", busy, 0);
    pw(8'h10, 8'd3);
    pw(8'h11, 8'd4);
    pw(8'h13, 8'h01);  chk("clr_busy_n1", busy, 1);
    pw(8'h10, 8'd7);   chk("clr_drop_col", cursor_col, 3);
    pw(8'h12, 8'h15);
    wait_idle("clr_timeout", cnt);
    chk("clr_len", cnt + 2, 4800);
    chk("clr_col", cursor_col, 0);
    chk("clr_row", cursor_row, 0);
    nz = 0;
    for (int i = 0; i <= 4800; i++) begin
      if (i < 4800) begin
        Qh = 10'((i % 80) * 8);
        Qv = 10'((i / 80) * 8);
      end
      tick();
      if (i >= 1 && DIR8x8[9:4] != 6'd0) nz++;
    end
    chk("clr_all_zero", nz, 0);
    pw(8'h10, 8'd9);   chk("post_clr_acc", cursor_col, 9);
`endif

    // ---- async reset (mid-clear when clear is built in) ----
    pw(8'h10, 8'd79);
    pw(8'h11, 8'd59);
    pw(8'h12, 8'h21); tick();
    pw(8'h10, 8'd5);
    pw(8'h11, 8'd5);
    rd_px(632, 477, v); chk("pre_rst_dir", v, 12'h215);
`ifdef CHAR_BUFFER_CLEAR_EN
    pw(8'h13, 8'h01);
    repeat (99) tick();
    chk("mid_clr_busy", busy, 1);
    chk("mid_clr_dir", DIR8x8, 12'h215);
`endif
    #3 resetM = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_col", cursor_col, 0);
    chk("arst_row", cursor_row, 0);
    chk("arst_dir", DIR8x8, 12'h000);
    tick();
    resetM = 1'b0;
`ifdef CHAR_BUFFER_CLEAR_EN
    tick();
    chk("reboot_busy", busy, 1);
    wait_idle("reboot_timeout", cnt);
    chk("reboot_len", cnt, 4800);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
